// File: rtl/accum_reg.sv
// accum_reg: accumulating register for the multiplier datapath.
// Holds the running product. The operand is a zero-extended, shifted copy of
// data_in_i. The register supports LOAD, ADD, CLEAR and HOLD, keeps a sticky
// carry-out flag, and counts ADDs, pulsing done_o once every NUM_ADDS of them.
// IN_WIDTH must not exceed WIDTH, and NUM_ADDS must be at least 1.
module accum_reg #(
    parameter int WIDTH    = 16,
    parameter int IN_WIDTH = 8,
    parameter int SHIFT    = 4,
    parameter int NUM_ADDS = 4,
    localparam int CNT_W   = $clog2(NUM_ADDS + 1)
) (
    input  logic                clk_i,
    input  logic                sclr_n_i,
    input  logic                clk_ena_i,
    input  logic [1:0]          op_i,
    input  logic [1:0]          shift_sel_i,
    input  logic [IN_WIDTH-1:0] data_in_i,
    output logic [WIDTH-1:0]    data_out_o,
    output logic                ovf_o,
    output logic [CNT_W-1:0]    add_cnt_o,
    output logic                done_o
);

    typedef enum logic [1:0] {
        OP_HOLD  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_ADD   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    // The headroom of 3*SHIFT bits lets the largest shift happen before truncation.
    localparam int EXT_W = WIDTH + 3 * SHIFT;

    logic [EXT_W-1:0] dataExt;
    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   sum;
    logic             lastAdd;
    op_e              opSel;

    logic [WIDTH-1:0] acc_q,  acc_d;
    logic             ovf_q,  ovf_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             done_q, done_d;

    assign dataExt = EXT_W'(data_in_i);
    assign opSel   = op_e'(op_i);
    assign sum     = {1'b0, acc_q} + {1'b0, operand};
    assign lastAdd = (cnt_q == CNT_W'(NUM_ADDS - 1));

    // Shift the operand by shift_sel*SHIFT and keep only the low WIDTH bits.
    // The bits shifted out at the top are dropped and never reach ovf.
    always_comb begin
        operand = '0;
        unique case (shift_sel_i)
            2'd0:    operand = WIDTH'(dataExt);
            2'd1:    operand = WIDTH'(dataExt << SHIFT);
            2'd2:    operand = WIDTH'(dataExt << (2 * SHIFT));
            default: operand = WIDTH'(dataExt << (3 * SHIFT));
        endcase
    end

    // Next-state logic. When the enable is low, everything holds, but done
    // always falls, so that it is a single-cycle pulse.
    always_comb begin
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clk_ena_i) begin
            unique case (opSel)
                OP_LOAD: begin
                    acc_d = operand;
                    ovf_d = 1'b0;
                    cnt_d = '0;
                end
                OP_ADD: begin
                    acc_d = sum[WIDTH-1:0];
                    ovf_d = ovf_q | sum[WIDTH];
                    if (lastAdd) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                OP_CLEAR: begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end
    end

    // State registers. A synchronous reset wins over the enable.
    always_ff @(posedge clk_i) begin
        if (!sclr_n_i) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign data_out_o = acc_q;
    assign ovf_o      = ovf_q;
    assign add_cnt_o  = cnt_q;
    assign done_o     = done_q;

endmodule
